// File: rtl/led_pkg.sv
// led_pkg: shared types and constants for the LED time-slice scheduler.
//   led_state_t  - scheduler FSM states
//   LED_W_DEF    - default LED bank width
//   DUR_W_DEF    - default duration field width (ticks)
//   cnt_width()  - bits needed for a counter running 0..n-1 (at least 1)
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } led_state_t;

  localparam int LED_W_DEF = 4;
  localparam int DUR_W_DEF = 16;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_rr_arb.sv
// led_rr_arb: combinational round-robin arbiter.
//   req       in   NUM_REQ          request vector
//   rr_ptr    in   $clog2(NUM_REQ)  highest-priority index for this search
//   enable    in   1                when low, nothing is granted
//   grant     out  NUM_REQ          one-hot grant
//   grant_idx out  $clog2(NUM_REQ)  index of the granted requester
//   any       out  1                a grant was made
// The pointer register lives in the parent; this block only searches.
module led_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       any
);

  localparam int IW = $clog2(NUM_REQ);

  // cand_idx[k] is the requester k positions after rr_ptr, wrapping.
  logic [IW-1:0]      cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IW:0] sum;
      assign sum = {1'b0, rr_ptr} + (IW+1)'(gi);
      assign cand_idx[gi] = (sum >= (IW+1)'(NUM_REQ)) ?
                            IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the smallest offset from rr_ptr wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    if (enable) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (cand_hit[k]) begin
          any       = 1'b1;
          grant_idx = cand_idx[k];
        end
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/led_sched.sv
// led_sched: round-robin time-sliced owner of the LED bank.
//   clk, rst     clock and synchronous active-high reset
//   req_valid    per-requester request (level-held until ready)
//   req_pattern  packed LED patterns, requester i at [i*LED_W +: LED_W]
//   req_dur      packed display durations in ticks, requester i at [i*DUR_W +: DUR_W]
//   req_ready    one-hot accept strobe (combinational)
//   flush        abort the current slot and return to IDLE
//   led          registered LED drive
//   busy         high while in SHOW or GAP
//   owner        index of the last granted requester
//   done         one-cycle pulse in the last cycle of a completed SHOW slot
module led_sched
  import led_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int LED_W     = LED_W_DEF,
  parameter int DUR_W     = DUR_W_DEF,
  parameter int CLK_DIV   = 10000,
  parameter int GAP_TICKS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*LED_W-1:0]   req_pattern,
  input  logic [NUM_REQ*DUR_W-1:0]   req_dur,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       flush,
  output logic [LED_W-1:0]           led,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int PW = cnt_width(CLK_DIV);

  led_state_t       state_reg, state_next;
  logic [PW-1:0]    presc_reg, presc_next;
  logic [DUR_W-1:0] dur_reg,   dur_next;
  logic [LED_W-1:0] led_reg,   led_next;
  logic [IW-1:0]    owner_reg, owner_next;
  logic [IW-1:0]    rr_reg,    rr_next;
  logic             busy_reg,  busy_next;
  logic             done_reg,  done_next;

  // Unpack the flat request buses.
  logic [LED_W-1:0] pat_arr [NUM_REQ];
  logic [DUR_W-1:0] dur_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign pat_arr[gi] = req_pattern[gi*LED_W +: LED_W];
      assign dur_arr[gi] = req_dur[gi*DUR_W +: DUR_W];
    end
  endgenerate

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;
  logic               arb_en;

  assign arb_en = (state_reg == IDLE) && !flush && !rst;

  led_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_reg),
    .enable    (arb_en),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  assign req_ready = grant;

  logic tick;
  assign tick = (presc_reg == PW'(CLK_DIV - 1));

  always_comb begin
    state_next = state_reg;
    presc_next = presc_reg;
    dur_next   = dur_reg;
    led_next   = led_reg;
    owner_next = owner_reg;
    rr_next    = rr_reg;

    case (state_reg)
      IDLE: begin
        presc_next = '0;
        if (grant_any) begin
          state_next = SHOW;
          led_next   = pat_arr[grant_idx];
          dur_next   = (dur_arr[grant_idx] == '0) ? DUR_W'(1) : dur_arr[grant_idx];
          owner_next = grant_idx;
          rr_next    = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      SHOW: begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
        if (tick) begin
          if (dur_reg == DUR_W'(1)) begin
            led_next = '0;
            if (GAP_TICKS == 0) begin
              state_next = IDLE;
              dur_next   = '0;
            end else begin
              state_next = GAP;
              dur_next   = DUR_W'(GAP_TICKS);
            end
          end else begin
            dur_next = dur_reg - 1'b1;
          end
        end
      end
      GAP: begin
        presc_next = tick ? '0 : presc_reg + 1'b1;
        if (tick) begin
          if (dur_reg == DUR_W'(1)) begin
            state_next = IDLE;
            dur_next   = '0;
          end else begin
            dur_next = dur_reg - 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        presc_next = '0;
        dur_next   = '0;
        led_next   = '0;
      end
    endcase

    if (flush) begin
      state_next = IDLE;
      presc_next = '0;
      dur_next   = '0;
      led_next   = '0;
    end

    busy_next = (state_next != IDLE);
    // done is registered, so raise it on the edge that enters the last
    // SHOW cycle (final count, prescaler about to reach its tick value).
    done_next = (state_next == SHOW) && (presc_next == PW'(CLK_DIV - 1)) &&
                (dur_next == DUR_W'(1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      presc_reg <= '0;
      dur_reg   <= '0;
      led_reg   <= '0;
      owner_reg <= '0;
      rr_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      presc_reg <= presc_next;
      dur_reg   <= dur_next;
      led_reg   <= led_next;
      owner_reg <= owner_next;
      rr_reg    <= rr_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign led   = led_reg;
  assign busy  = busy_reg;
  assign owner = owner_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_led_sched.sv
module tb_led_sched;

  localparam int NUM_REQ = 4;
  localparam int LED_W   = 4;
  localparam int DUR_W   = 16;
  localparam int CLK_DIV = 10;
  localparam int GAP_T   = 1;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*LED_W-1:0] req_pattern;
  logic [NUM_REQ*DUR_W-1:0] req_dur;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     flush;
  logic [LED_W-1:0]         led;
  logic                     busy;
  logic [1:0]               owner;
  logic                     done;

  int n_vec = 0;
  int n_err = 0;

  led_sched #(
    .NUM_REQ(NUM_REQ), .LED_W(LED_W), .DUR_W(DUR_W),
    .CLK_DIV(CLK_DIV), .GAP_TICKS(GAP_T)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_pattern(req_pattern),
    .req_dur(req_dur), .req_ready(req_ready), .flush(flush), .led(led),
    .busy(busy), .owner(owner), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int idx, input logic [3:0] pat, input logic [15:0] dur);
    req_pattern[idx*LED_W +: LED_W] = pat;
    req_dur[idx*DUR_W +: DUR_W]     = dur;
  endtask

  // Starts in an IDLE cycle where requester idx should be granted; ends in
  // the first IDLE cycle after the gap.
  task automatic slot(input int idx, input logic [3:0] pat, input int ticks, input bit drop);
    int n;
    logic [3:0] one;
    n = ticks * CLK_DIV;
    one = 4'b0001 << idx;
    check("ready_grant", 32'(req_ready), 32'(one));
    step();
    if (drop) req_valid[idx] = 1'b0;
    check("owner", 32'(owner), 32'(idx));
    for (int i = 0; i < n; i++) begin
      check("led_show", 32'(led), 32'(pat));
      check("busy_show", 32'(busy), 32'(1));
      check("done_show", 32'(done), 32'(i == n - 1));
      check("ready_show", 32'(req_ready), 32'(0));
      step();
    end
    for (int i = 0; i < GAP_T * CLK_DIV; i++) begin
      check("led_gap", 32'(led), 32'(0));
      check("busy_gap", 32'(busy), 32'(1));
      check("done_gap", 32'(done), 32'(0));
      step();
    end
    check("busy_idle", 32'(busy), 32'(0));
    $display("slot req%0d pattern %0h ticks %0d complete", idx, pat, ticks);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    req_valid = 4'hF;
    req_pattern = '0;
    req_dur = '0;
    set_req(0, 4'h1, 16'd1);
    set_req(1, 4'h2, 16'd1);
    set_req(2, 4'h4, 16'd1);
    set_req(3, 4'h8, 16'd1);

    // Reset held 5 cycles with all requests pending.
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_ready", 32'(req_ready), 32'(0));
      check("rst_led", 32'(led), 32'(0));
      check("rst_busy", 32'(busy), 32'(0));
      check("rst_owner", 32'(owner), 32'(0));
    end
    $display("reset: 5 cycles checked");
    rst = 1'b0;
    #1;

    // Round-robin with all requesters valid.
    slot(0, 4'h1, 1, 1'b0);
    slot(1, 4'h2, 1, 1'b0);
    slot(2, 4'h4, 1, 1'b0);
    slot(3, 4'h8, 1, 1'b0);
    slot(0, 4'h1, 1, 1'b0);
    req_valid = 4'h0;

    // Single request, duration 3 (pointer at 1, wraps to 0).
    set_req(0, 4'hA, 16'd3);
    req_valid = 4'h1;
    #1;
    slot(0, 4'hA, 3, 1'b1);

    // Duration 0 treated as one tick.
    set_req(2, 4'h5, 16'd0);
    req_valid = 4'h4;
    #1;
    slot(2, 4'h5, 1, 1'b1);

    // Flush mid-SHOW: req1 for 5 ticks, flush in its 17th cycle.
    set_req(1, 4'h3, 16'd5);
    req_valid = 4'h2;
    #1;
    check("fl_ready", 32'(req_ready), 32'(4'h2));
    step();
    check("fl_owner", 32'(owner), 32'(1));
    req_valid = 4'h6;
    for (int i = 1; i < 17; i++) begin
      check("fl_led", 32'(led), 32'(4'h3));
      step();
    end
    flush = 1'b1;
    #1;
    check("fl_led17", 32'(led), 32'(4'h3));
    check("fl_done17", 32'(done), 32'(0));
    step();
    flush = 1'b0;
    #1;
    check("fl_led_off", 32'(led), 32'(0));
    check("fl_busy_off", 32'(busy), 32'(0));
    check("fl_done_off", 32'(done), 32'(0));
    check("fl_owner_held", 32'(owner), 32'(1));
    $display("flush mid-SHOW: slot aborted");
    slot(2, 4'h5, 1, 1'b1);
    req_valid = 4'h0;

    // Flush together with a request in IDLE.
    flush = 1'b1;
    req_valid = 4'h1;
    #1;
    check("fi_ready", 32'(req_ready), 32'(0));
    step();
    check("fi_busy", 32'(busy), 32'(0));
    check("fi_led", 32'(led), 32'(0));
    flush = 1'b0;
    #1;
    check("fi_ready_after", 32'(req_ready), 32'(4'h1));
    step();
    check("fi_owner", 32'(owner), 32'(0));
    check("fi_busy_after", 32'(busy), 32'(1));
    check("fi_led_after", 32'(led), 32'(4'hA));
    $display("flush with valid in IDLE: grant delayed one cycle");
    req_valid = 4'h0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_sched.md
# led_sched

Time-sliced scheduler that shares the board LED bank between several requesters. Each requester posts a pattern and a display duration via a valid/ready handshake. The block grants requesters round-robin, drives the granted pattern for the requested number of prescaler ticks, inserts a blank gap, then re-arbitrates. It sits between the application-level status sources and the LED pins, replacing direct drive of the `led` outputs.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- LED_W, 4, LED bank width
- DUR_W, 16, duration field width (ticks)
- CLK_DIV, 10000, clock cycles per tick (1 ms at 10 MHz); ≥2
- GAP_TICKS, 1, blank ticks between slots; 0 skips GAP
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request
- req_pattern  in  NUM_REQ*LED_W  packed patterns; requester i at [i*LED_W +: LED_W]
- req_dur  in  NUM_REQ*DUR_W  packed durations in ticks
- req_ready  out  NUM_REQ  one-hot accept strobe
- flush  in  1  abort current slot, return to IDLE
- led  out  LED_W  LED drive, registered
- busy  out  1  high in SHOW or GAP
- owner  out  $clog2(NUM_REQ)  index of last granted requester
- done  out  1  one-cycle pulse when a SHOW slot completes normally

## Operation
- States: IDLE, SHOW, GAP.
- IDLE: the arbiter searches req_valid starting at rr_ptr, wrapping. If any bit is set, req_ready[g] is driven combinationally, and the transfer happens that edge.
  - On transfer: latch pattern and duration, owner<=g, rr_ptr<=(g+1) mod NUM_REQ, next state SHOW.
- SHOW: led=latched pattern. The prescaler restarts on entry. The duration counter decrements on each tick.
  - On the final tick: done pulses, then go to GAP, or to IDLE if GAP_TICKS=0.
- GAP: led=0 for GAP_TICKS ticks, then IDLE.
- req_ready is 0 outside IDLE, during rst, and during flush.
- Duration 0 is treated as 1.
- Requests are level-held by the requester until ready. The block never drops a pending request. Non-granted requesters keep waiting.
- Arbitration fairness: with all requesters valid, grants occur in order 0,1,2,3,0,…
- flush (any state): next edge state=IDLE, led=0, prescaler cleared, no done pulse. rr_ptr and owner are held.
  - flush and valid together in IDLE: flush wins, no ready.
- Reset values: state=IDLE, led=0, busy=0, owner=0, done=0, rr_ptr=0, prescaler=0, duration counter=0.
  - Reset mid-slot abandons the slot without done.

## Timing
- Handshake at edge E → led shows the pattern from E+1. busy is high from E+1.
- SHOW lasts exactly max(dur,1)×CLK_DIV cycles.
- done is high in the last SHOW cycle.
- GAP lasts GAP_TICKS×CLK_DIV cycles.
- Earliest next ready: first IDLE cycle after GAP, i.e. one IDLE cycle minimum between slots.
- Tick is internal: prescaler counts 0..CLK_DIV-1, and tick is asserted at CLK_DIV-1.
- All outputs are registered except req_ready, which is combinational from state, req_valid, rr_ptr and flush.

## Structure
- Package led_pkg holds:
  - state enum (IDLE, SHOW, GAP)
  - default LED_W and DUR_W constants
  - the tick-count width function
- Sub-module led_rr_arb: parameterised NUM_REQ round-robin arbiter.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant, grant index, any.
  - Purely combinational; rr_ptr is owned by led_sched.
- Prescaler, duration counter and FSM stay in led_sched.

## Test plan
(All scenarios use CLK_DIV=10, GAP_TICKS=1.)
- Reset: hold rst 5 cycles with req_valid=4'hF.
  - Expect req_ready=0, led=0, busy=0, owner=0 throughout.
  - First grant after release goes to requester 0.
- Single request: req0 pattern 4'hA, dur 3.
  - Ready pulses once.
  - led=4'hA for exactly 30 cycles, done in the 30th.
  - Then led=0 for 10 cycles, busy falls, IDLE.
- Round-robin: all four valid, patterns 1,2,4,8, dur 1.
  - led sequence 1,2,4,8,1.
  - Each slot is 10 cycles, separated by 10-cycle gaps plus one IDLE cycle.
  - owner sequence is 0,1,2,3,0.
- Duration 0: req2 dur 0, pattern 4'h5.
  - Shown for exactly 10 cycles with done asserted.
- Flush mid-SHOW: req1 dur 5, assert flush at cycle 17 of SHOW.
  - led=0 next cycle, no done, state IDLE.
  - With req1 and req2 both still valid, the next grant is req2 (rr_ptr preserved).
- Flush with valid in IDLE: flush and req_valid=4'h1 in the same cycle.
  - No ready that cycle.
  - Grant occurs the cycle after flush drops.
